// File: rtl/acumulador_ca2_pkg.sv
// acc_ca2_pkg: shared types and constants for the two's-complement accumulator.
//   op_e  : operation code carried on the op bus (ADD/SUB/LOAD/CLEAR)
//   st_e  : output-register occupancy state (EMPTY/FULL)
//   FLAG_*: bit positions of the Z/Ng/C/V flags inside the 4-bit flags word
package acc_ca2_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } st_e;

    localparam int unsigned FLAG_Z  = 3;
    localparam int unsigned FLAG_NG = 2;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_V  = 0;

endpackage

// File: rtl/acumulador_ca2_if.sv
// acumulador_ca2_if: valid/ready operand bus and result bus of the accumulator.
//   in_valid/in_ready   : operand handshake (operand N bits, op 2 bits)
//   out_valid/out_ready : result handshake (acc N bits, flags 4 bits)
//   slave  modport : seen from the accumulator
//   master modport : seen from the producer/consumer driving it
interface acumulador_ca2_if #(
    parameter int unsigned N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] operand;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc;
    logic [3:0]   flags;

    modport slave (
        input  in_valid, operand, op, out_ready,
        output in_ready, out_valid, acc, flags
    );

    modport master (
        output in_valid, operand, op, out_ready,
        input  in_ready, out_valid, acc, flags
    );
endinterface

// File: rtl/acumulador_ca2_sumador.sv
// sumador_cin: N-bit ripple-carry adder with carry-in.
//   a, b : N-bit addends
//   cin  : carry into bit 0
//   sum  : N-bit result (modulo 2^N)
//   cout : carry out of bit N-1
module sumador_cin #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/acumulador_ca2.sv
// acumulador_ca2: registered two's-complement accumulator (ADD/SUB/LOAD/CLEAR)
// with a one-entry output register and valid/ready on both sides.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : acumulador_ca2_if.slave (in_valid/in_ready/operand/op,
//           out_valid/out_ready/acc/flags; flags = {Z, Ng, C, V})
// Optional build macro ACUMULADOR_SATURATE_EN: on ADD/SUB signed overflow the
// accumulator clamps to the signed max/min instead of wrapping.
module acumulador_ca2
    import acc_ca2_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    acumulador_ca2_if.slave  bus
);

    st_e          state;
    st_e          state_next;
    logic         out_valid_w;
    logic         in_ready_w;
    logic         accept;

    op_e          op_sel;
    logic [N-1:0] add_b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         v_ovf;
    logic         c_next;
    logic         v_next;
    logic [N-1:0] acc_next;
    logic [3:0]   flags_next;
    logic [N-1:0] acc_q;
    logic [3:0]   flags_q;

    // Output FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (bus.out_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Output FSM: outputs and handshake
    always_comb begin
        out_valid_w = (state == ST_FULL);
        in_ready_w  = !out_valid_w || bus.out_ready;
        accept      = bus.in_valid && in_ready_w;
        bus.out_valid = out_valid_w;
        bus.in_ready  = in_ready_w;
    end

    // SUB reuses the adder as acc + ~operand + 1; the operand is never
    // negated on its own, so the most-negative value subtracts exactly.
    always_comb begin
        op_sel = op_e'(bus.op);
        add_b  = (op_sel == OP_SUB) ? ~bus.operand : bus.operand;
        cin    = (op_sel == OP_SUB);
    end

    sumador_cin #(.N(N)) u_sumador (
        .a    (acc_q),
        .b    (add_b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        v_ovf    = (acc_q[N-1] == add_b[N-1]) && (sum[N-1] != acc_q[N-1]);
        acc_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        unique case (op_sel)
            OP_ADD, OP_SUB: begin
                acc_next = sum;
                c_next   = cout;
                v_next   = v_ovf;
`ifdef ACUMULADOR_SATURATE_EN
                // Overflow direction follows the accumulator's sign.
                if (v_ovf) begin
                    acc_next = acc_q[N-1] ? {1'b1, {(N-1){1'b0}}}
                                          : {1'b0, {(N-1){1'b1}}};
                end
`endif
            end
            OP_LOAD:  acc_next = bus.operand;
            OP_CLEAR: acc_next = '0;
            default:  acc_next = '0;
        endcase
        flags_next          = '0;
        flags_next[FLAG_Z]  = (acc_next == '0);
        flags_next[FLAG_NG] = acc_next[N-1];
        flags_next[FLAG_C]  = c_next;
        flags_next[FLAG_V]  = v_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            flags_q <= '0;
        end else if (accept) begin
            acc_q   <= acc_next;
            flags_q <= flags_next;
        end
    end

    always_comb begin
        bus.acc   = acc_q;
        bus.flags = flags_q;
    end

endmodule

// File: tb/tb_acumulador_ca2.sv
module tb_acumulador_ca2;

    localparam int unsigned N = 4;
    localparam int MAXS = (1 << (N - 1)) - 1;
    localparam int MINS = -(1 << (N - 1));

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    acumulador_ca2_if #(.N(N)) bus ();

    acumulador_ca2 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference state
    logic [N-1:0] m_acc;
    logic [3:0]   m_flags;
    logic         m_ov;

    function automatic int to_signed(input logic [N-1:0] x);
        int u;
        u = int'(x);
        return x[N-1] ? u - (1 << N) : u;
    endfunction

    function automatic void model_op(input logic [1:0] o, input logic [N-1:0] b);
        int sa, sb, sr;
        int ua, ub;
        logic c, v;
        logic [N-1:0] res;
        sa = to_signed(m_acc);
        sb = to_signed(b);
        ua = int'(m_acc);
        ub = int'(b);
        c  = 1'b0;
        v  = 1'b0;
        sr = 0;
        case (o)
            2'b00: begin sr = sa + sb; c = (ua + ub) >= (1 << N); end
            2'b01: begin sr = sa - sb; c = (ua >= ub); end
            2'b10: sr = sb;
            default: sr = 0;
        endcase
        res = sr[N-1:0];
        if (o == 2'b00 || o == 2'b01) begin
            v = (sr > MAXS) || (sr < MINS);
`ifdef ACUMULADOR_SATURATE_EN
            if (v) res = (sa >= 0) ? N'(MAXS) : N'(MINS);
`endif
        end
        m_acc   = res;
        m_flags = {(res == '0), res[N-1], c, v};
    endfunction

    task automatic drive(input logic v, input logic [1:0] o,
                         input logic [N-1:0] b, input logic rdy);
        bus.in_valid  = v;
        bus.op        = o;
        bus.operand   = b;
        bus.out_ready = rdy;
    endtask

    // Advances one clock, updating the reference from the inputs seen at the edge.
    task automatic tick();
        logic acc_now;
        acc_now = bus.in_valid && (!m_ov || bus.out_ready);
        if (!rst_n) begin
            m_acc = '0; m_flags = '0; m_ov = 1'b0;
        end else begin
            if (acc_now) model_op(bus.op, bus.operand);
            m_ov = acc_now ? 1'b1 : (bus.out_ready ? 1'b0 : m_ov);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 4'd5, 1'b0);
        tick();
        tick();
        total++; if (bus.acc !== 4'b0000) begin bad++; $display("FAIL reset_acc got=%b exp=0000", bus.acc); end
        total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [1:0] d_op [8];
        logic [3:0] d_b  [8];
        logic [3:0] d_acc[8];
        logic [3:0] d_fl [8];
        d_op = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
        d_b  = '{4'b0011, 4'b0101, 4'b0000, 4'b1000, 4'b0111, 4'b0001, 4'b0111, 4'b0111};
`ifdef ACUMULADOR_SATURATE_EN
        d_acc = '{4'b0011, 4'b1110, 4'b0000, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0000};
        d_fl  = '{4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1010};
`else
        d_acc = '{4'b0011, 4'b1110, 4'b0000, 4'b1000, 4'b0111, 4'b1000, 4'b0111, 4'b0000};
        d_fl  = '{4'b0000, 4'b0100, 4'b1000, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b1010};
`endif
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, d_op[i], d_b[i], 1'b1);
            tick();
            total++; if (bus.acc !== d_acc[i]) begin bad++; $display("FAIL dir%0d_acc got=%b exp=%b", i, bus.acc, d_acc[i]); end
            total++; if (bus.flags !== d_fl[i]) begin bad++; $display("FAIL dir%0d_flags got=%b exp=%b", i, bus.flags, d_fl[i]); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_out_valid got=%b exp=1", i, bus.out_valid); end
        end
        drive(1'b0, 2'b00, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'b10, 4'b0010, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 4'b0001, 1'b0);
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_in_ready got=%b exp=0", i, bus.in_ready); end
            tick();
            total++; if (bus.acc !== 4'b0010) begin bad++; $display("FAIL bp%0d_acc_hold got=%b exp=0010", i, bus.acc); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_out_valid got=%b exp=1", i, bus.out_valid); end
        end
        drive(1'b1, 2'b00, 4'b0001, 1'b1);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.acc !== 4'b0011) begin bad++; $display("FAIL bp_release_acc got=%b exp=0011", bus.acc); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_no_bubble got=%b exp=1", bus.out_valid); end
        drive(1'b0, 2'b00, 4'd0, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [1:0] o;
        for (int i = 0; i < 300; i++) begin
            o = 2'($urandom_range(0, 3));
            if (o == 2'b11 && $urandom_range(0, 3) != 0) o = 2'b00;
            drive(1'($urandom_range(0, 3) != 0), o, 4'($urandom), 1'($urandom_range(0, 2) != 0));
            #1;
            total++; if (bus.in_ready !== (!m_ov || bus.out_ready)) begin bad++; $display("FAIL rnd%0d_in_ready got=%b exp=%b", i, bus.in_ready, (!m_ov || bus.out_ready)); end
            tick();
            total++; if (bus.acc !== m_acc) begin bad++; $display("FAIL rnd%0d_acc got=%b exp=%b", i, bus.acc, m_acc); end
            total++; if (bus.flags !== m_flags) begin bad++; $display("FAIL rnd%0d_flags got=%b exp=%b", i, bus.flags, m_flags); end
            total++; if (bus.out_valid !== m_ov) begin bad++; $display("FAIL rnd%0d_out_valid got=%b exp=%b", i, bus.out_valid, m_ov); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'b10, 4'b0101, 1'b1);
        tick();
        drive(1'b1, 2'b00, 4'b0011, 1'b1);
        rst_n = 1'b0;
        tick();
        total++; if (bus.acc !== 4'b0000) begin bad++; $display("FAIL rstmid_acc got=%b exp=0000", bus.acc); end
        total++; if (bus.flags !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%b exp=0000", bus.flags); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        tick();
    endtask

    initial begin
        m_acc   = '0;
        m_flags = '0;
        m_ov    = 1'b0;
        rst_n   = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
